// File: rtl/const_materializer_pkg.sv
// Shared constants and types for the LUI/ORI constant materializer.
// Opcodes, FSM state encoding and the I-type word layout.
package const_materializer_pkg;

  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EMIT_LUI = 2'd1,
    EMIT_ORI = 2'd2
  } state_e;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } itype_t;

endpackage

// File: rtl/const_materializer_itype_encoder.sv
// Combinational MIPS I-type encoder.
// Packs op/rs/rt/imm into op[31:26] rs[25:21] rt[20:16] imm[15:0].
module itype_encoder
  import const_materializer_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [15:0] imm_i,
  output logic [31:0] instr_o
);

  itype_t word;

  // Field packing through the shared layout struct.
  always_comb begin
    word     = '0;
    word.op  = op_i;
    word.rs  = rs_i;
    word.rt  = rt_i;
    word.imm = imm_i;
    instr_o  = word;
  end

endmodule

// File: rtl/const_materializer.sv
// Turns a 32-bit constant + rt into a LUI/ORI instruction stream.
// Valid/ready on both sides; all outputs registered.
module const_materializer
  import const_materializer_pkg::*;
#(
  parameter int FORCE_PAIR = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      req_data_i,
  input  logic [4:0]       req_rt_i,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [31:0]      instr_o,
  output logic             instr_last_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] emit_cnt_o
);

  localparam logic FP = (FORCE_PAIR != 0);

  state_e      state_q, state_d;
  logic [15:0] hi_q, hi_d;
  logic [15:0] lo_q, lo_d;
  logic [4:0]  rt_q, rt_d;
  logic        lui_q, lui_d;
  logic        single_q, single_d;

  logic             req_ready_q, req_ready_d;
  logic             valid_q, valid_d;
  logic [31:0]      instr_q, instr_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0]  enc_op;
  logic [4:0]  enc_rs;
  logic [4:0]  enc_rt;
  logic [15:0] enc_imm;
  logic [31:0] enc_word;

  logic accept;
  logic xfer;

  assign accept = req_valid_i && req_ready_q;
  assign xfer   = valid_q && instr_ready_i;

  itype_encoder u_enc (
    .op_i    (enc_op),
    .rs_i    (enc_rs),
    .rt_i    (enc_rt),
    .imm_i   (enc_imm),
    .instr_o (enc_word)
  );

  // State and captured request registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      rt_q     <= '0;
      lui_q    <= 1'b0;
      single_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      rt_q     <= rt_d;
      lui_q    <= lui_d;
      single_q <= single_d;
    end
  end

  // Next state: capture on accept, advance only on transfer.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    rt_d     = rt_q;
    lui_d    = lui_q;
    single_d = single_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          hi_d     = req_data_i[31:16];
          lo_d     = req_data_i[15:0];
          rt_d     = req_rt_i;
          lui_d    = FP || (req_data_i[31:16] != 16'd0);
          single_d = !FP && (req_data_i[31:16] != 16'd0)
                     && (req_data_i[15:0] == 16'd0);
          state_d  = lui_d ? EMIT_LUI : EMIT_ORI;
        end
      end
      EMIT_LUI: begin
        if (xfer) state_d = single_q ? IDLE : EMIT_ORI;
      end
      EMIT_ORI: begin
        if (xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output words derived from the upcoming state, registered below.
  always_comb begin
    enc_op      = OP_LUI;
    enc_rs      = REG_ZERO;
    enc_rt      = rt_d;
    enc_imm     = hi_d;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    req_ready_d = (state_d == IDLE);
    unique case (state_d)
      EMIT_LUI: begin
        valid_d = 1'b1;
        last_d  = single_d;
      end
      EMIT_ORI: begin
        enc_op  = OP_ORI;
        enc_rs  = lui_d ? rt_d : REG_ZERO;
        enc_imm = lo_d;
        valid_d = 1'b1;
        last_d  = 1'b1;
      end
      default: ;
    endcase
    instr_d = valid_d ? enc_word : 32'd0;
    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, xfer};
  end

  // Registered handshake outputs and transfer counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      req_ready_q <= 1'b0;
      valid_q     <= 1'b0;
      instr_q     <= '0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      req_ready_q <= req_ready_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_last_o  = last_q;
  assign busy_o        = (state_q != IDLE);
  assign emit_cnt_o    = cnt_q;

endmodule

// File: tb/tb_const_materializer.sv
// Directed bench for const_materializer.
// Two instances: default (drop redundant half) and forced pair.
module tb_const_materializer;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic [4:0]  req_rt;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        last;
  logic        busy;
  logic [15:0] cnt;

  logic        f_req_valid;
  logic        f_req_ready;
  logic [31:0] f_req_data;
  logic [4:0]  f_req_rt;
  logic        f_instr_valid;
  logic        f_instr_ready;
  logic [31:0] f_instr;
  logic        f_last;
  logic        f_busy;
  logic [15:0] f_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  const_materializer #(.FORCE_PAIR(0), .CNT_W(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_data_i    (req_data),
    .req_rt_i      (req_rt),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .instr_last_o  (last),
    .busy_o        (busy),
    .emit_cnt_o    (cnt)
  );

  const_materializer #(.FORCE_PAIR(1), .CNT_W(16)) dut_fp (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .req_valid_i   (f_req_valid),
    .req_ready_o   (f_req_ready),
    .req_data_i    (f_req_data),
    .req_rt_i      (f_req_rt),
    .instr_valid_o (f_instr_valid),
    .instr_ready_i (f_instr_ready),
    .instr_o       (f_instr),
    .instr_last_o  (f_last),
    .busy_o        (f_busy),
    .emit_cnt_o    (f_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] r);
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_wait ready=%b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_data  = d;
    req_rt    = r;
    tick();
    req_valid = 1'b0;
    req_data  = 32'hA5A5_A5A5;
    req_rt    = 5'd31;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({req_ready, instr_valid, last, busy} !== 4'b0000
        || instr !== 32'd0 || cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_vals rdy=%b v=%b l=%b b=%b i=%h c=%0d required all 0",
               req_ready, instr_valid, last, busy, instr, cnt);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge got %b required 0", req_ready);
    end
    tick();
    checks++;
    if (req_ready !== 1'b1 || f_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release got %b/%b required 1/1",
               req_ready, f_req_ready);
    end
  endtask

  task automatic test_pair;
    instr_ready = 1'b1;
    send(32'h1234_5678, 5'd8);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h3C08_1234 || last !== 1'b0
        || busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL pair_lui v=%b i=%h l=%b b=%b r=%b required 1 3c081234 0 1 0",
               instr_valid, instr, last, busy, req_ready);
    end
    tick();
    exp_cnt++;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h3508_5678 || last !== 1'b1
        || cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL pair_ori v=%b i=%h l=%b c=%0d required 1 35085678 1 %0d",
               instr_valid, instr, last, cnt, exp_cnt);
    end
    tick();
    exp_cnt++;
    checks++;
    if (instr_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1
        || cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL pair_done v=%b b=%b r=%b c=%0d required 0 0 1 %0d",
               instr_valid, busy, req_ready, cnt, exp_cnt);
    end
  endtask

  task automatic test_single;
    logic [31:0] vals [3];
    logic [4:0]  rts  [3];
    logic [31:0] exps [3];
    vals[0] = 32'h0000_00FF; rts[0] = 5'd9;  exps[0] = 32'h3409_00FF;
    vals[1] = 32'hDEAD_0000; rts[1] = 5'd10; exps[1] = 32'h3C0A_DEAD;
    vals[2] = 32'h0000_0000; rts[2] = 5'd3;  exps[2] = 32'h3403_0000;
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send(vals[k], rts[k]);
      checks++;
      if (instr_valid !== 1'b1 || instr !== exps[k] || last !== 1'b1) begin
        errors++;
        $display("FAIL single_word[%0d] v=%b i=%h l=%b required 1 %h 1",
                 k, instr_valid, instr, last, exps[k]);
      end
      tick();
      exp_cnt++;
      checks++;
      if (instr_valid !== 1'b0 || req_ready !== 1'b1
          || cnt !== 16'(exp_cnt)) begin
        errors++;
        $display("FAIL single_done[%0d] v=%b r=%b c=%0d required 0 1 %0d",
                 k, instr_valid, req_ready, cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_force_pair;
    f_instr_ready = 1'b1;
    f_req_valid   = 1'b1;
    f_req_data    = 32'h0000_0007;
    f_req_rt      = 5'd8;
    tick();
    f_req_valid = 1'b0;
    checks++;
    if (f_instr_valid !== 1'b1 || f_instr !== 32'h3C08_0000
        || f_last !== 1'b0) begin
      errors++;
      $display("FAIL fp_lui v=%b i=%h l=%b required 1 3c080000 0",
               f_instr_valid, f_instr, f_last);
    end
    tick();
    checks++;
    if (f_instr_valid !== 1'b1 || f_instr !== 32'h3508_0007
        || f_last !== 1'b1) begin
      errors++;
      $display("FAIL fp_ori v=%b i=%h l=%b required 1 35080007 1",
               f_instr_valid, f_instr, f_last);
    end
    tick();
    checks++;
    if (f_instr_valid !== 1'b0 || f_cnt !== 16'd2 || f_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL fp_done v=%b c=%0d r=%b required 0 2 1",
               f_instr_valid, f_cnt, f_req_ready);
    end
  endtask

  task automatic test_backpressure;
    instr_ready = 1'b0;
    send(32'h1234_5678, 5'd8);
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1;
      req_data  = 32'h0000_0011;
      req_rt    = 5'd1;
      tick();
      checks++;
      if (instr !== 32'h3C08_1234 || last !== 1'b0 || instr_valid !== 1'b1
          || cnt !== 16'(exp_cnt) || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_lui_hold[%0d] i=%h l=%b v=%b c=%0d r=%b required 3c081234 0 1 %0d 0",
                 k, instr, last, instr_valid, cnt, req_ready, exp_cnt);
      end
    end
    req_valid   = 1'b0;
    instr_ready = 1'b1;
    tick();
    exp_cnt++;
    instr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_valid = k[0];
      tick();
      checks++;
      if (instr !== 32'h3508_5678 || last !== 1'b1
          || cnt !== 16'(exp_cnt)) begin
        errors++;
        $display("FAIL bp_ori_hold[%0d] i=%h l=%b c=%0d required 35085678 1 %0d",
                 k, instr, last, cnt, exp_cnt);
      end
    end
    req_valid   = 1'b0;
    instr_ready = 1'b1;
    tick();
    exp_cnt++;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || busy !== 1'b0 || cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL bp_no_ghost v=%b b=%b c=%0d required 0 0 %0d",
               instr_valid, busy, cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid;
    instr_ready = 1'b1;
    send(32'h1234_5678, 5'd8);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    checks++;
    if (instr_valid !== 1'b0 || cnt !== 16'd0 || instr !== 32'd0
        || busy !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset v=%b c=%0d i=%h b=%b r=%b required 0 0 0 0 0",
               instr_valid, cnt, instr, busy, req_ready);
    end
    #3;
    rst_n = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ready r=%b v=%b required 1 0",
               req_ready, instr_valid);
    end
    send(32'h0000_00FF, 5'd9);
    checks++;
    if (instr !== 32'h3409_00FF || last !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_word i=%h l=%b required 340900ff 1",
               instr, last);
    end
    tick();
    exp_cnt++;
    checks++;
    if (cnt !== 16'(exp_cnt) || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_cnt c=%0d v=%b required %0d 0",
               cnt, instr_valid, exp_cnt);
    end
  endtask

  initial begin
    req_valid     = 1'b0;
    req_data      = '0;
    req_rt        = '0;
    instr_ready   = 1'b0;
    f_req_valid   = 1'b0;
    f_req_data    = '0;
    f_req_rt      = '0;
    f_instr_ready = 1'b0;
    test_reset();
    test_pair();
    test_single();
    test_force_pair();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/const_materializer.md
Name: const_materializer

Overview:
- Reverse direction of the immediate zero-fill path. The datapath turns a LUI immediate into a register value; this block takes a 32-bit constant plus a target register and produces the MIPS I-type instruction stream (LUI/ORI) that builds that constant.
- Sits between the test/boot instruction injector and instruction memory write port.
- Valid/ready handshake on both sides. Sequenced by a small FSM with an emitted-word counter.

Parameters:
- FORCE_PAIR, 0, 1 = always emit LUI+ORI; 0 = drop the redundant instruction when a half is zero.
- CNT_W, 16, width of the emitted-instruction counter.

Ports:
- clk_i  input  1  system clock; all state updates on its rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  a constant request is presented.
- req_ready_o  output  1  block can accept a request.
- req_data_i  input  32  constant to materialize.
- req_rt_i  input  5  destination register number.
- instr_valid_o  output  1  instr_o holds a valid instruction word.
- instr_ready_i  input  1  consumer accepts instr_o.
- instr_o  output  32  encoded instruction word.
- instr_last_o  output  1  current word is the final word of this request.
- busy_o  output  1  request captured and not fully emitted.
- emit_cnt_o  output  CNT_W  total words transferred since reset.

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE, req_ready_o=0, instr_valid_o=0, instr_o=0, instr_last_o=0, busy_o=0, emit_cnt_o=0, captured data/rt cleared.
- req_ready_o is registered. It goes to 1 on the first clk_i edge after reset release, is 1 only in IDLE, and drops the edge after an accept.
- Accept: req_valid_i && req_ready_o at an edge captures hi=req_data_i[31:16], lo=req_data_i[15:0] and rt. busy_o=1 from the next cycle.
- States: IDLE, EMIT_LUI, EMIT_ORI.
- Transitions on accept from IDLE:
  - FORCE_PAIR=1 or (hi!=0 and lo!=0): go to EMIT_LUI.
  - hi!=0 and lo==0: go to EMIT_LUI, with LUI marked last.
  - hi==0 (includes value 0): go to EMIT_ORI.
- EMIT_LUI output: instr_o = {6'b001111, 5'd0, rt, hi}. instr_valid_o=1. instr_last_o=1 only in the single-LUI case.
- EMIT_ORI output:
  - After a LUI: instr_o = {6'b001101, rt, rt, lo}.
  - Without a LUI: instr_o = {6'b001101, 5'd0, rt, lo}.
  - instr_last_o=1 in both cases.
- Latency: the first word is valid in the cycle after accept. Output signals are registered.
- Output hold: while instr_valid_o && !instr_ready_i, instr_o, instr_last_o and the state are held unchanged.
- Transfer (instr_valid_o && instr_ready_i at an edge):
  - emit_cnt_o increments and wraps modulo 2^CNT_W.
  - Non-last word: advance to EMIT_ORI and present the ORI word in the next cycle.
  - Last word: go to IDLE with instr_valid_o=0, busy_o=0, req_ready_o=1 in the next cycle. There is no same-cycle re-accept.
- Minimum throughput: pair = 3 cycles per request, single = 2 cycles per request.
- rt=0 is encoded as given, with no special case.
- req_valid_i outside IDLE is ignored. req_data_i is sampled only at accept.
- Reset asserted mid-sequence aborts the request immediately: outputs drop to reset values asynchronously, and the partial sequence is not resumed.

Decomposition:
- Shared package:
  - OP_LUI=6'b001111, OP_ORI=6'b001101, REG_ZERO=5'd0.
  - State encoding: IDLE=2'd0, EMIT_LUI=2'd1, EMIT_ORI=2'd2.
  - I-type field positions: op[31:26], rs[25:21], rt[20:16], imm[15:0].
- Sub-module itype_encoder: combinational, takes op/rs/rt/imm and produces the 32-bit word. Instantiated once and driven by the FSM muxes.

Test Plan:
- 0x12345678, rt=8, instr_ready_i=1 -> 0x3C081234 (last=0), then 0x35085678 (last=1); emit_cnt_o=2; req_ready_o=1 one cycle after the second transfer.
- 0x000000FF, rt=9 -> single word 0x340900FF, last=1; emit_cnt_o+=1.
- 0xDEAD0000, rt=10 -> single word 0x3C0ADEAD, last=1. Value 0x00000000, rt=3 -> 0x34030000, last=1.
- FORCE_PAIR=1, 0x00000007, rt=8 -> 0x3C080000 then 0x35080007.
- 0x12345678 with instr_ready_i=0 for 4 cycles on each word -> instr_o stable at 0x3C081234 throughout; no counter change; req_valid_i pulses while busy are ignored.
- rst_i low during EMIT_ORI of 0x12345678 -> instr_valid_o=0, emit_cnt_o=0 immediately; after release, req_ready_o=1 one edge later and a new request emits normally.
